// File: rtl/buffer_reader.sv
// Read-side streamer for the synchronous dual-port buffer: issues sequential reads and
// hides the one-cycle read latency behind a 4-entry output FIFO with credit-based issue.
module buffer_reader #(
  parameter int G_BUF_ADDR_WIDTH = 10,
  parameter int G_BUF_DATA_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [G_BUF_ADDR_WIDTH:0]   len_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [G_BUF_ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [G_BUF_DATA_WIDTH-1:0] buf_data_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [G_BUF_DATA_WIDTH-1:0] m_data_o,
  output logic                        m_last_o
);

  localparam int AW = G_BUF_ADDR_WIDTH;
  localparam int DW = G_BUF_DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LEN_ZERO = {(AW+1){1'b0}};

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [AW-1:0] addr_r;
  logic [AW:0]   remain_r;
  logic          infl_valid_r;
  logic          infl_last_r;
  logic [DW-1:0] fifo_data_r [0:3];
  logic          fifo_last_r [0:3];
  logic [1:0]    wr_ptr_r;
  logic [1:0]    rd_ptr_r;
  logic [2:0]    count_r;
  logic          done_r;

  logic accept_s;
  logic zero_s;
  logic credit_s;
  logic issue_s;
  logic last_issue_s;
  logic push_s;
  logic pop_s;
  logic finish_s;

  // Command decode, credit check and stream handshake
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && start_i && (len_i != LEN_ZERO);
    zero_s       = (state_r == ST_IDLE) && start_i && (len_i == LEN_ZERO);
    // Words already in the FIFO plus the one in flight must leave room for one more
    credit_s     = ({1'b0, count_r} + {3'b000, infl_valid_r}) < 4'd4;
    issue_s      = (state_r == ST_READ) && credit_s;
    last_issue_s = issue_s && (remain_r == LEN_ONE);
    push_s       = infl_valid_r;
    pop_s        = (count_r != 3'd0) && m_ready_i;
    finish_s     = pop_s && fifo_last_r[rd_ptr_r];
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_READ;
        else          state_nxt_s = ST_IDLE;
      end
      ST_READ: begin
        if (last_issue_s) state_nxt_s = ST_DRAIN;
        else              state_nxt_s = ST_READ;
      end
      ST_DRAIN: begin
        if (finish_s) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state, read address, remaining count, in-flight tracker and done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      addr_r       <= {AW{1'b0}};
      remain_r     <= LEN_ZERO;
      infl_valid_r <= 1'b0;
      infl_last_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      infl_valid_r <= issue_s;
      infl_last_r  <= last_issue_s;
      done_r       <= zero_s || finish_s;
      if (accept_s) begin
        addr_r   <= base_addr_i;
        remain_r <= len_i;
      end else if (issue_s) begin
        addr_r   <= addr_r + ADDR_ONE;
        remain_r <= remain_r - LEN_ONE;
      end else begin
        addr_r   <= addr_r;
        remain_r <= remain_r;
      end
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        fifo_data_r[i] <= {DW{1'b0}};
        fifo_last_r[i] <= 1'b0;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= buf_data_i;
        fifo_last_r[wr_ptr_r] <= infl_last_r;
        wr_ptr_r              <= wr_ptr_r + 2'd1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
      else       rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign busy_o    = (state_r != ST_IDLE);
  assign done_o    = done_r;
  assign rd_addr_o = addr_r;
  assign m_valid_o = (count_r != 3'd0);
  assign m_data_o  = fifo_data_r[rd_ptr_r];
  assign m_last_o  = (count_r != 3'd0) && fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader: table of transfers plus reset, len=0 and
// mid-transfer reset sequences, against a behavioural model of the buffer.
module tb_buffer_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        busy;
  logic        done;
  logic [9:0]  rd_addr;
  logic [7:0]  buf_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    logic [3:0]  pat;
    int          inj;
    logic [9:0]  exp_end_addr;
  } vec_t;

  vec_t vecs [0:4];

  buffer_reader #(.G_BUF_ADDR_WIDTH(10), .G_BUF_DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
    .len_i(len), .busy_o(busy), .done_o(done), .rd_addr_o(rd_addr),
    .buf_data_i(buf_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_last_o(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], 6'b000000} ^ 8'h5A;
  endfunction

  // Buffer model: one-cycle registered read
  always @(posedge clk) buf_data <= mem_f(rd_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int cyc, idx, first_valid;
    logic pv, pr, seen_done;
    logic [7:0] pd;
    logic [9:0] a;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; len = v.len; m_ready = 1'b1;
    cyc = 0; idx = 0; first_valid = 0; pv = 1'b0; pr = 1'b0; pd = 8'h00; seen_done = 1'b0;
    while (!seen_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (v.inj != 0 && cyc == v.inj);
      if (start) begin base_addr = 10'h200; len = 11'd5; end
      m_ready = v.pat[(cyc-1)%4];
      if (cyc == 1) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("first_rd_addr", 32'(rd_addr), 32'(v.base));
      end
      if (v.pat == 4'hF && cyc <= int'(v.len)) begin
        a = v.base + 10'(cyc - 1);
        check("rd_addr_seq", 32'(rd_addr), 32'(a));
      end
      if (pv && !pr) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(pd));
      end
      if (m_valid && first_valid == 0) begin
        first_valid = cyc;
        check("first_valid_cycle", 32'(first_valid), 32'd3);
      end
      if (m_valid && m_ready) begin
        a = v.base + 10'(idx);
        check("data", 32'(m_data), 32'(mem_f(a)));
        check("last", 32'(m_last), 32'(idx == int'(v.len) - 1));
        idx++;
      end
      if (done) begin
        seen_done = 1'b1;
        check("words_at_done", 32'(idx), 32'(v.len));
        check("busy_at_done", 32'(busy), 32'd0);
        if (v.pat == 4'hF) check("done_cycle", 32'(cyc), 32'(int'(v.len) + 3));
      end
      pv = m_valid; pr = m_ready; pd = m_data;
    end
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("valid_idle", 32'(m_valid), 32'd0);
    check("rd_addr_hold", 32'(rd_addr), 32'(v.exp_end_addr));
    m_ready = 1'b1;
  endtask

  initial begin
    int idx;
    vecs[0] = '{base: 10'h010, len: 11'd4,  pat: 4'b1111, inj: 0, exp_end_addr: 10'h014};
    vecs[1] = '{base: 10'h3FE, len: 11'd4,  pat: 4'b1111, inj: 0, exp_end_addr: 10'h002};
    vecs[2] = '{base: 10'h0F0, len: 11'd16, pat: 4'b1001, inj: 0, exp_end_addr: 10'h100};
    vecs[3] = '{base: 10'h100, len: 11'd8,  pat: 4'b1111, inj: 3, exp_end_addr: 10'h108};
    vecs[4] = '{base: 10'h3FC, len: 11'd8,  pat: 4'b0101, inj: 0, exp_end_addr: 10'h004};

    rst_n = 1'b0; start = 1'b0; base_addr = 10'h000; len = 11'd0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);

    // Zero-length command
    start = 1'b1; base_addr = 10'h155; len = 11'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("len0_done_end", 32'(done), 32'd0);
    check("len0_valid2", 32'(m_valid), 32'd0);
    check("len0_rd_addr", 32'(rd_addr), 32'd0);

    for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

    // Reset after three words of a ten-word transfer
    @(negedge clk);
    start = 1'b1; base_addr = 10'h000; len = 11'd10; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 50 && idx < 3; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) idx++;
    end
    check("mid_words_seen", 32'(idx), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data", 32'(m_data), 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(m_valid), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
    end
    run_xfer('{base: 10'h020, len: 11'd2, pat: 4'b1111, inj: 0, exp_end_addr: 10'h022});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
